// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding, select constants and output decode for the GCD controller.
`default_nettype none

package gcd_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_A  = 3'd1,
      LOAD_B  = 3'd2,
      COMPARE = 3'd3,
      SUB_A   = 3'd4,
      SUB_B   = 3'd5,
      DONE    = 3'd6,
      ERR     = 3'd7
   } state_t;

   localparam logic SEL_A   = 1'b0;
   localparam logic SEL_B   = 1'b1;
   localparam logic SEL_SUB = 1'b0;
   localparam logic SEL_DIN = 1'b1;

   typedef struct packed {
      logic ldA;
      logic ldB;
      logic sel1;
      logic sel2;
      logic sel_in;
      logic busy;
      logic done;
      logic err;
   } ctrl_t;

   function automatic ctrl_t decode(state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         LOAD_A:  begin c.sel_in = SEL_DIN; c.ldA = 1'b1; c.busy = 1'b1; end
         LOAD_B:  begin c.sel_in = SEL_DIN; c.ldB = 1'b1; c.busy = 1'b1; end
         COMPARE: c.busy = 1'b1;
         SUB_A:   begin
            c.sel1 = SEL_A; c.sel2 = SEL_B; c.sel_in = SEL_SUB;
            c.ldA  = 1'b1;  c.busy = 1'b1;
         end
         SUB_B:   begin
            c.sel1 = SEL_B; c.sel2 = SEL_A; c.sel_in = SEL_SUB;
            c.ldB  = 1'b1;  c.busy = 1'b1;
         end
         DONE:    c.done = 1'b1;
         ERR:     begin c.done = 1'b1; c.err = 1'b1; end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_datapath.sv
// gcd_datapath: 16-bit A/B registers with a shared subtractor and magnitude flags.
`default_nettype none

module gcd_datapath
   import gcd_pkg::*;
(
   input  logic        clk,
   input  logic [15:0] data_in,
   input  logic        ldA,
   input  logic        ldB,
   input  logic        sel1,
   input  logic        sel2,
   input  logic        sel_in,
   output logic        gt,
   output logic        lt,
   output logic        eq,
   output logic [15:0] a_val
);

   logic [15:0] a, b, minuend, subtrahend, bus;

   assign minuend    = (sel1 == SEL_B) ? b : a;
   assign subtrahend = (sel2 == SEL_B) ? b : a;
   assign bus        = (sel_in == SEL_DIN) ? data_in : (minuend - subtrahend);

   // No reset: the registers keep their contents across a controller abort.
   always_ff @(posedge clk) begin
      if (ldA) a <= bus;
      if (ldB) b <= bus;
   end

   assign gt    = (a > b);
   assign lt    = (a < b);
   assign eq    = (a == b);
   assign a_val = a;

endmodule

`default_nettype wire

// File: rtl/gcd_iter_cnt.sv
// gcd_iter_cnt: subtraction watchdog counter; saturates at MAX_ITER and flags at_max.
`default_nettype none

module gcd_iter_cnt #(
   parameter int MAX_ITER = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic at_max
);

   localparam int W = $clog2(MAX_ITER + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + W'(1);
      end
   end

   assign at_max = (count == W'(MAX_ITER));

endmodule

`default_nettype wire

// File: rtl/gcd_controller.sv
// gcd_controller: Moore control FSM for the subtract-and-compare GCD datapath.
// Optional iteration watchdog compiled in with GCD_CTRL_TIMEOUT_EN.
`default_nettype none

module gcd_controller
   import gcd_pkg::*;
#(
   parameter int MAX_ITER = 65535
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic gt,
   input  logic lt,
   input  logic eq,
   output logic ldA,
   output logic ldB,
   output logic sel1,
   output logic sel2,
   output logic sel_in,
   output logic busy,
   output logic done,
   output logic err
);

   state_t state, nxt;
   ctrl_t  ctl;
   logic   at_max;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = LOAD_A;
         LOAD_A:  nxt = LOAD_B;
         LOAD_B:  nxt = COMPARE;
         COMPARE: begin
            if (eq)      nxt = DONE;
            else if (gt) nxt = at_max ? ERR : SUB_A;
            else if (lt) nxt = at_max ? ERR : SUB_B;
         end
         SUB_A, SUB_B: nxt = COMPARE;
         DONE, ERR:    if (start) nxt = LOAD_A;
         default:      nxt = IDLE;
      endcase
   end

`ifdef GCD_CTRL_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
   logic cnt_clr, cnt_inc;

   assign cnt_clr = (state == LOAD_A);
   assign cnt_inc = (state == COMPARE) && ((nxt == SUB_A) || (nxt == SUB_B));

   gcd_iter_cnt #(
      .MAX_ITER (MAX_ITER)
   ) u_iter_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .inc    (cnt_inc),
      .at_max (at_max)
   );
`else
   localparam bit TIMEOUT_EN = 1'b0;
   logic unused_max_iter;

   assign at_max          = 1'b0;
   assign unused_max_iter = (MAX_ITER == 0);
`endif

   // Outputs are registered from the decode of the next state, so they track the state register.
   assign ctl = decode(nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ldA    <= 1'b0;
         ldB    <= 1'b0;
         sel1   <= 1'b0;
         sel2   <= 1'b0;
         sel_in <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         state  <= nxt;
         ldA    <= ctl.ldA;
         ldB    <= ctl.ldB;
         sel1   <= ctl.sel1;
         sel2   <= ctl.sel2;
         sel_in <= ctl.sel_in;
         busy   <= ctl.busy;
         done   <= ctl.done;
         err    <= ctl.err & TIMEOUT_EN;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed test of gcd_controller paired with gcd_datapath.
`default_nettype none

module tb_gcd_controller;

`ifdef GCD_CTRL_TIMEOUT_EN
   localparam int MAX_ITER = 4;
`else
   localparam int MAX_ITER = 65535;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] data_in = 16'd0;
   logic        gt, lt, eq;
   logic        ldA, ldB, sel1, sel2, sel_in, busy, done, err;
   logic [15:0] a_val;
   logic [7:0]  outs;

   int n_assert = 0;
   int n_fail   = 0;

   // Results of the most recent run
   int done_cyc;
   int subs;
   bit overlap;
   bit reload;
   bit first_ok;

   assign outs = {ldA, ldB, sel1, sel2, sel_in, busy, done, err};

   always #5 clk = ~clk;

   gcd_controller #(.MAX_ITER(MAX_ITER)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .gt     (gt),
      .lt     (lt),
      .eq     (eq),
      .ldA    (ldA),
      .ldB    (ldB),
      .sel1   (sel1),
      .sel2   (sel2),
      .sel_in (sel_in),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   gcd_datapath u_dp (
      .clk     (clk),
      .data_in (data_in),
      .ldA     (ldA),
      .ldB     (ldB),
      .sel1    (sel1),
      .sel2    (sel2),
      .sel_in  (sel_in),
      .gt      (gt),
      .lt      (lt),
      .eq      (eq),
      .a_val   (a_val)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one computation starting from IDLE/DONE/ERR; optionally pulses start in cycle pulse_cyc.
   task automatic run(input logic [15:0] a, input logic [15:0] b, input int pulse_cyc);
      int cyc;
      subs = 0; overlap = 0; reload = 0; done_cyc = -1;
      start = 1'b1; data_in = a;
      @(posedge clk); #1;
      cyc = 1;
      start = 1'b0;
      first_ok = ldA && sel_in && !ldB && !done && busy;
      while (!(done && cyc > 1) && cyc < 300) begin
         if (ldA && ldB) overlap = 1;
         if ((ldA || ldB) && !sel_in) subs++;
         if (cyc > 2 && sel_in) reload = 1;
         start = (cyc == pulse_cyc);
         if (cyc == pulse_cyc) data_in = 16'h00FF;
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) data_in = b;
      end
      start = 1'b0;
      if (done) done_cyc = cyc;
   endtask

   initial begin
      // Reset state
      #12;
      check("reset_outs", 32'(outs), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_outs", 32'(outs), 32'd0);

      // Reset in the middle of SUB_A (A=12, B=8: cycle 4 is SUB_A)
      start = 1'b1; data_in = 16'd12;
      @(posedge clk); #1; start = 1'b0;
      @(posedge clk); #1; data_in = 16'd8;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("in_sub_a", 32'({ldA, sel_in, sel1, sel2}), 32'b1001);
      #2 rst_n = 1'b0;
      #1 check("abort_outs", 32'(outs), 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1 check("abort_no_done", 32'({busy, done}), 32'd0);

      // A=7, B=7
      run(16'd7, 16'd7, 0);
      check("eq_first", 32'(first_ok), 32'd1);
      check("eq_done_cyc", 32'(done_cyc), 32'd4);
      check("eq_subs", 32'(subs), 32'd0);
      check("eq_result", 32'(a_val), 32'd7);
      check("eq_err", 32'(err), 32'd0);

      // A=12, B=8
      run(16'd12, 16'd8, 0);
      check("r12_8_done_cyc", 32'(done_cyc), 32'd8);
      check("r12_8_subs", 32'(subs), 32'd2);
      check("r12_8_result", 32'(a_val), 32'd4);

      // A=35, B=14, then back-to-back A=9, B=6
      run(16'd35, 16'd14, 0);
      check("r35_14_done_cyc", 32'(done_cyc), 32'd10);
      check("r35_14_overlap", 32'(overlap), 32'd0);
      check("r35_14_result", 32'(a_val), 32'd7);
      run(16'd9, 16'd6, 0);
      check("b2b_first", 32'(first_ok), 32'd1);
      check("b2b_done_cyc", 32'(done_cyc), 32'd8);
      check("b2b_result", 32'(a_val), 32'd3);

      // start pulsed during the first COMPARE is ignored
      run(16'd12, 16'd8, 3);
      check("pulse_reload", 32'(reload), 32'd0);
      check("pulse_done_cyc", 32'(done_cyc), 32'd8);
      check("pulse_result", 32'(a_val), 32'd4);

`ifdef GCD_CTRL_TIMEOUT_EN
      // A=0, B=5 never converges: watchdog trips
      run(16'd0, 16'd5, 0);
      check("wd_done_cyc", 32'(done_cyc), 32'd12);
      check("wd_subs", 32'(subs), 32'd4);
      check("wd_err", 32'({done, err}), 32'b11);
      @(posedge clk); #1;
      check("wd_err_held", 32'({done, err, busy}), 32'b110);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
